// File: rtl/axi_sram_pkg.sv
// -----------------------------------------------------------------------------
// axi_sram_pkg
// Shared definitions for the AXI-style SRAM slave: response codes, delay
// counter width and the read/write FSM state encodings.
// -----------------------------------------------------------------------------
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Wide enough for any LFSR delay (0..15) and for LATENCY values up to 255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_ACK  = 2'd2,
    W_RESP = 2'd3
  } w_state_t;

endpackage

// File: rtl/axi_sram_lfsr.sv
// -----------------------------------------------------------------------------
// axi_sram_lfsr
// 4-bit Fibonacci LFSR, polynomial x^4+x^3+1, free-running every cycle.
// Seeded to 4'b1001 on reset; supplies random wait counts to both FSMs.
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   out  out  current LFSR state (never 0)
// -----------------------------------------------------------------------------
module axi_sram_lfsr (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= 4'b1001;
    end else begin
      out <= {out[2:0], out[3] ^ out[2]};
    end
  end

endmodule

// File: rtl/axi_sram.sv
// -----------------------------------------------------------------------------
// axi_sram
// Simplified AXI-style single-port-array SRAM slave with independent read and
// write FSMs, one outstanding transaction each, and a programmable wait count.
// Build option: define RAND_DELAY_EN to take the wait count from a shared
// 4-bit LFSR (axi_sram_lfsr) instead of the LATENCY parameter.
//
// Parameters: DEPTH_LOG2 (array has 2^DEPTH_LOG2 32-bit words), BASE (byte
//             address of word 0), LATENCY (fixed wait count).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   arvalid/araddr/arready         read address channel
//   rvalid/rready/rdata/rresp      read data channel
//   awvalid/awaddr/awready         write address channel
//   wvalid/wdata/wstrb/wready      write data channel (wstrb[7:4] ignored)
//   bvalid/bready/bresp            write response channel
// -----------------------------------------------------------------------------
module axi_sram
  import axi_sram_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        awready,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0] mem [WORDS];

  // Wait count loaded into a counter at each address handshake.
  logic [CNT_W-1:0] dly;

`ifdef RAND_DELAY_EN
  logic [3:0] lfsr_out;

  axi_sram_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr_out)
  );

  assign dly = {{(CNT_W-4){1'b0}}, lfsr_out};
`else
  assign dly = CNT_W'(LATENCY);
`endif

  // Address lies inside [BASE, BASE + 4*WORDS).
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (addr >= BASE) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  // ---------------------------------------------------------------- read FSM
  r_state_t               r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [31:0]            r_addr;
  logic [31:0]            r_off;
  logic [DEPTH_LOG2-1:0]  r_idx;

  assign r_off = r_addr - BASE;
  assign r_idx = r_off[DEPTH_LOG2+1:2];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_cnt   <= dly;
            arready <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == '0) begin
            // Sampling here means a write committing on this same edge is
            // not yet visible: the read returns the pre-write word.
            rvalid  <= 1'b1;
            r_state <= R_DATA;
            if (in_range(r_addr)) begin
              rdata <= mem[r_idx];
              rresp <= RESP_OKAY;
            end else begin
              rdata <= '0;
              rresp <= RESP_SLVERR;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write FSM
  w_state_t               w_state;
  logic [CNT_W-1:0]       w_cnt;
  logic [31:0]            w_addr;
  logic [31:0]            w_data;
  logic [3:0]             w_strb;
  logic [31:0]            w_off;
  logic [DEPTH_LOG2-1:0]  w_idx;

  assign w_off = w_addr - BASE;
  assign w_idx = w_off[DEPTH_LOG2+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && wvalid) begin
            w_addr  <= awaddr;
            w_data  <= wdata;
            w_strb  <= wstrb[3:0];
            w_cnt   <= dly;
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt == '0) begin
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_ACK;
          end else begin
            w_cnt <= w_cnt - CNT_W'(1);
          end
        end
        W_ACK: begin
          awready <= 1'b0;
          wready  <= 1'b0;
          bvalid  <= 1'b1;
          bresp   <= in_range(w_addr) ? RESP_OKAY : RESP_SLVERR;
          w_state <= W_RESP;
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array write port: commits the latched write at the end of W_ACK.
  // NOTE: the array has no reset branch; clearing it would turn the RAM into
  // flops and contents are meant to survive a reset anyway.
  always_ff @(posedge clk) begin
    if (w_state == W_ACK && in_range(w_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Bits that are deliberately not consumed (upper strobes, address offset
  // bits outside the word index).
  logic unused_bits;
  assign unused_bits = ^{wstrb[7:4], r_off, w_off};

endmodule

// File: tb/tb_axi_sram.sv
// -----------------------------------------------------------------------------
// tb_axi_sram
// Self-checking bench for axi_sram: directed scenarios with literal
// expectations plus a randomized concurrent phase, all compared every cycle
// against a transaction-level model (word map + timing arithmetic).
// -----------------------------------------------------------------------------
module tb_axi_sram;

  localparam int          DL        = 10;
  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
  localparam int          LAT       = 1;
  localparam int          TO        = 64;

  logic        clk;
  logic        rst;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        wvalid;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        awready;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  axi_sram #(
    .DEPTH_LOG2 (DL),
    .BASE       (BASE_ADDR),
    .LATENCY    (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .arvalid (arvalid),
    .araddr  (araddr),
    .arready (arready),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .awvalid (awvalid),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .awready (awready),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------ model state
  int          cyc   = 0;
  logic        rst_q = 1'b1;
  logic [3:0]  m_lfsr = 4'b1001;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_q  <= rst;
    m_lfsr <= rst ? 4'b1001 : {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end

  function automatic int cur_delay();
`ifdef RAND_DELAY_EN
    return int'(m_lfsr);
`else
    return LAT;
`endif
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE_ADDR);
    return (off >= 0) && (off < 4 * (longint'(1) << DL));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE_ADDR)) / 4);
  endfunction

  logic [31:0] mdl [int];

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
  endfunction

  // Monitor-owned transaction state.
  logic        r_busy = 1'b0, w_busy = 1'b0;
  int          r_due, w_due;
  logic [31:0] r_a, w_a, w_d, r_exp_d;
  logic [1:0]  r_exp_r, w_exp_r;
  logic [3:0]  w_s;
  logic        pend_v = 1'b0;
  logic [31:0] pend_a, pend_d;
  logic [3:0]  pend_s;
  logic        exp_rv, exp_aw, exp_bv;

  task automatic commit_pending();
    logic [31:0] w;
    if (pend_v) begin
      w = mdl_rd(pend_a);
      for (int b = 0; b < 4; b++) if (pend_s[b]) w[8*b +: 8] = pend_d[8*b +: 8];
      mdl[widx(pend_a)] = w;
      pend_v = 1'b0;
    end
  endtask

  // Every-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_q) begin
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        commit_pending();
        r_busy = 1'b0;
        w_busy = 1'b0;
      end else begin
        exp_rv = r_busy && (cyc >= r_due);
        if (exp_rv && cyc == r_due) begin
          r_exp_d = in_rng(r_a) ? mdl_rd(r_a) : 32'h0;
          r_exp_r = in_rng(r_a) ? 2'b00 : 2'b10;
        end
        exp_aw = w_busy && (cyc == w_due);
        exp_bv = w_busy && (cyc > w_due);
        check("arready", 32'(arready), 32'(!r_busy));
        check("rvalid",  32'(rvalid),  32'(exp_rv));
        check("rdata",   rdata,        exp_rv ? r_exp_d : 32'h0);
        check("rresp",   32'(rresp),   exp_rv ? 32'(r_exp_r) : 32'd0);
        check("awready", 32'(awready), 32'(exp_aw));
        check("wready",  32'(wready),  32'(exp_aw));
        check("bvalid",  32'(bvalid),  32'(exp_bv));
        check("bresp",   32'(bresp),   exp_bv ? 32'(w_exp_r) : 32'd0);
        // A write acked last cycle lands in the array at this cycle's edge,
        // after any read sampled on that same edge.
        commit_pending();
        if (exp_aw && in_rng(w_a)) begin
          pend_v = 1'b1; pend_a = w_a; pend_d = w_d; pend_s = w_s;
        end
        if (exp_rv && rready) begin
          r_busy = 1'b0;
        end else if (!r_busy && arvalid) begin
          r_busy = 1'b1; r_a = araddr; r_due = cyc + cur_delay() + 2;
        end
        if (exp_bv && bready) begin
          w_busy = 1'b0;
        end else if (!w_busy && awvalid && wvalid) begin
          w_busy  = 1'b1; w_a = awaddr; w_d = wdata; w_s = wstrb[3:0];
          w_due   = cyc + cur_delay() + 2;
          w_exp_r = in_rng(awaddr) ? 2'b00 : 2'b10;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  logic rand_en = 1'b0, rready_fix = 1'b1, bready_fix = 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rready = rand_en ? 1'($urandom_range(0, 1)) : rready_fix;
      bready = rand_en ? 1'($urandom_range(0, 1)) : bready_fix;
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                          output logic [1:0] resp, output int ack_lat);
    int n, t0;
    @(posedge clk);
    #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
    t0 = cyc + 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < TO);
    check("wr_ack_timeout", 32'(awready), 32'd1);
    ack_lat = cyc - t0;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; awaddr = $urandom; wdata = $urandom; wstrb = 8'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < TO);
    check("wr_resp_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    while (!(bvalid && bready) && n < TO) begin @(negedge clk); n++; end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk);
    #1;
    arvalid = 1'b1; araddr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < TO);
    check("rd_addr_timeout", 32'(arready), 32'd1);
    @(posedge clk);
    #1;
    arvalid = 1'b0; araddr = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < TO);
    check("rd_data_timeout", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    while (!(rvalid && rready) && n < TO) begin @(negedge clk); n++; end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] rd, rd2;
  logic [1:0]  rs, bs;
  int          lat;

  initial begin
    rst = 1'b1; arvalid = 1'b0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; rready = 1'b1; bready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("arready_in_reset", 32'(arready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("arready_after_reset", 32'(arready), 32'd1);

    // Basic write then read.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, bs, lat);
    check("basic_bresp", 32'(bs), 32'd0);
`ifndef RAND_DELAY_EN
    check("basic_ack_latency", 32'(lat), 32'd2);
`endif
    do_read(32'h8000_0010, rd, rs);
    check("basic_rdata", rd, 32'hDEAD_BEEF);
    check("basic_rresp", 32'(rs), 32'd0);

    // Partial strobes; upper strobe bits must be ignored.
    do_write(32'h8000_0020, 32'h1122_3344, 8'h0F, bs, lat);
    do_write(32'h8000_0022, 32'hAABB_CCDD, 8'hA5, bs, lat);
    do_read(32'h8000_0020, rd, rs);
    check("strobe_rdata", rd, 32'h11BB_33DD);

    // Out-of-range read and write; word 0 is where a wrapped index would land.
    do_write(32'h8000_0000, 32'hCAFE_F00D, 8'h0F, bs, lat);
    do_read(32'h7FFF_FFFC, rd, rs);
    check("oor_rresp", 32'(rs), 32'd2);
    check("oor_rdata", rd, 32'h0);
    do_write(32'h8000_1000, 32'h1234_5678, 8'h0F, bs, lat);
    check("oor_bresp", 32'(bs), 32'd2);
    do_read(32'h8000_0000, rd, rs);
    check("oor_array_unchanged", rd, 32'hCAFE_F00D);

    // Back-pressure: rready low for 5 cycles while data is held.
    rready_fix = 1'b0;
    fork
      do_read(32'h8000_0010, rd, rs);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < TO);
        rd2 = rdata;
        repeat (5) begin
          @(posedge clk);
          @(negedge clk);
          check("bp_rvalid_held", 32'(rvalid), 32'd1);
          check("bp_rdata_held", rdata, 32'hDEAD_BEEF);
          check("bp_arready_low", 32'(arready), 32'd0);
        end
        rready_fix = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after_rready", 32'(arready), 32'd1);
        check("bp_rvalid_dropped", 32'(rvalid), 32'd0);
      end
    join
    check("bp_first_rdata", rd2, 32'hDEAD_BEEF);

    // Same-cycle collision: read sample coincides with the write commit.
    do_write(32'h8000_0040, 32'h0, 8'h0F, bs, lat);
    fork
      do_write(32'h8000_0040, 32'h5, 8'h0F, bs, lat);
      begin @(posedge clk); do_read(32'h8000_0040, rd, rs); end
    join
`ifndef RAND_DELAY_EN
    check("collision_old_value", rd, 32'h0);
`endif
    do_read(32'h8000_0040, rd, rs);
    check("collision_new_value", rd, 32'h5);

    // Reset while the write FSM is waiting.
    @(posedge clk);
    #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h8000_0010; wdata = 32'h0BAD_C0DE; wstrb = 8'h0F;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstw_arready_after", 32'(arready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("rstw_no_bvalid", 32'(bvalid), 32'd0);
    end
    do_read(32'h8000_0010, rd, rs);
    check("rstw_word_unchanged", rd, 32'hDEAD_BEEF);

    // Randomized concurrent traffic over a pre-written pool of words.
    for (int k = 0; k < 8; k++) do_write(32'h8000_0200 + 32'(4 * k), $urandom, 8'h0F, bs, lat);
    rand_en = 1'b1;
    fork
      begin
        logic [31:0] a; logic [1:0] r; int l;
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          case ($urandom_range(0, 9))
            0:       a = 32'h8000_0000 - 32'(4 * $urandom_range(1, 4));
            1:       a = 32'h8000_1000 + 32'(4 * $urandom_range(0, 100));
            default: a = 32'h8000_0200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
          endcase
          do_write(a, $urandom, 8'($urandom), r, l);
        end
      end
      begin
        logic [31:0] a, d; logic [1:0] r;
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          case ($urandom_range(0, 9))
            0:       a = 32'h7FFF_FFFC - 32'(4 * $urandom_range(0, 4));
            1:       a = 32'h8000_1000 + 32'(4 * $urandom_range(0, 100));
            default: a = 32'h8000_0200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
          endcase
          do_read(a, d, r);
        end
      end
    join
    rand_en = 1'b0;
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
